// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- 8N1 UART transmitter fed by a first-word-fall-through FIFO.
//
// Bytes written by the host are queued in the FIFO. A x16 baud-enable
// generator paces a start/data/stop state machine that drains the queue onto
// an idle-high serial line, LSB first. When a stop bit ends and another byte is
// already waiting, the next start bit follows with no idle gap.
//
// Ports:
//   clk_tx             in   system clock
//   rst_clk_tx         in   synchronous active-high reset
//   tx_data[7:0]       in   byte to enqueue
//   write_en           in   push tx_data this cycle (dropped while full)
//   txd_tx             out  registered serial line, idle high
//   tx_fifo_full       out  FIFO holds FIFO_DEPTH entries
//   tx_fifo_empty      out  FIFO holds no entries
//   lost_data          out  sticky: a write was attempted while full
//   tx_busy            out  a frame is on the line
//   tx_frame_indicator out  state: 0 idle, 1 start, 2 data, 3 stop
//   tx_bit_indicator   out  one-cycle pulse on the last tick of every bit

module uart_tx_fifo #(
  parameter int BAUD_RATE  = 115_200,
  parameter int CLOCK_RATE = 50_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_tx,
  input  logic       rst_clk_tx,
  input  logic [7:0] tx_data,
  input  logic       write_en,
  output logic       txd_tx,
  output logic       tx_fifo_full,
  output logic       tx_fifo_empty,
  output logic       lost_data,
  output logic       tx_busy,
  output logic [1:0] tx_frame_indicator,
  output logic       tx_bit_indicator
);

  // Rounded divide: adding half the denominator before truncating.
  localparam int DIV_RAW = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DIVISOR = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int BAUD_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(DIVISOR - 1);
  localparam logic [AW:0]       COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Baud generator: one-cycle enable every DIVISOR clocks (every clock when 1).
  // ---------------------------------------------------------------------------
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic              baud_en;

  assign baud_en    = (baud_cnt_q == BAUD_LAST);
  assign baud_cnt_d = baud_en ? '0 : baud_cnt_q + BAUD_W'(1);

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          lost_q, lost_d;
  logic          push, pop;
  logic [7:0]    head;

  // Full is taken from the registered flag, so a write while full is dropped
  // even when the FSM pops in the same cycle.
  assign push = write_en && !full_q;
  assign head = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; the pointers and count define which entries
  // are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_tx) begin
    if (push && !rst_clk_tx) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    lost_d = lost_q | (write_en & full_q);
  end

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] os_cnt_q, os_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;
  logic       bit_ind_q, bit_ind_d;
  logic       bit_end;

  assign bit_end = baud_en && (os_cnt_q == 4'd15);

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (baud_en && !empty_q) begin
          pop      = 1'b1;
          shift_d  = head;
          os_cnt_d = 4'd0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_en) os_cnt_d = os_cnt_q + 4'd1;
        if (bit_end) begin
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_en) os_cnt_d = os_cnt_q + 4'd1;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_en) os_cnt_d = os_cnt_q + 4'd1;
        if (bit_end) begin
          // Chain straight into the next frame when a byte is waiting.
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The line is driven from the next state so it changes on the same edge
    // as the state register.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase

    // Registered pulse aligned to the last tick of a bit: predict that the
    // coming cycle carries the sixteenth baud enable of the bit.
    bit_ind_d = (state_d != ST_IDLE) && (os_cnt_d == 4'd15) &&
                (baud_cnt_d == BAUD_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_tx) begin
    if (rst_clk_tx) begin
      baud_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      lost_q     <= 1'b0;
      state_q    <= ST_IDLE;
      os_cnt_q   <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
      bit_ind_q  <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == COUNT_FULL);
      empty_q    <= (count_d == '0);
      lost_q     <= lost_d;
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      bit_ind_q  <= bit_ind_d;
    end
  end

  assign txd_tx             = txd_q;
  assign tx_fifo_full       = full_q;
  assign tx_fifo_empty      = empty_q;
  assign lost_data          = lost_q;
  assign tx_busy            = (state_q != ST_IDLE);
  assign tx_frame_indicator = state_q;
  assign tx_bit_indicator   = bit_ind_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- directed bench for uart_tx_fifo.
//
// Two instances share one clock: u_dut_a runs with DIVISOR=1 (one baud enable
// per clock, 16-cycle bits) and u_dut_b with CLOCK_RATE=50 MHz (DIVISOR=27,
// 432-cycle bits). Expected line activity comes from a small frame model driven
// by the list of bytes that should appear on the wire.

module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, wr_a, txd_a, full_a, empty_a, lost_a, busy_a, bit_a;
  logic [7:0] data_a;
  logic [1:0] frame_a;
  logic       rst_b, wr_b, txd_b, full_b, empty_b, lost_b, busy_b, bit_b;
  logic [7:0] data_b;
  logic [1:0] frame_b;

  uart_tx_fifo #(
    .BAUD_RATE (115_200),
    .CLOCK_RATE(1_843_200),
    .FIFO_DEPTH(16)
  ) u_dut_a (
    .clk_tx            (clk),
    .rst_clk_tx        (rst_a),
    .tx_data           (data_a),
    .write_en          (wr_a),
    .txd_tx            (txd_a),
    .tx_fifo_full      (full_a),
    .tx_fifo_empty     (empty_a),
    .lost_data         (lost_a),
    .tx_busy           (busy_a),
    .tx_frame_indicator(frame_a),
    .tx_bit_indicator  (bit_a)
  );

  uart_tx_fifo #(
    .BAUD_RATE (115_200),
    .CLOCK_RATE(50_000_000),
    .FIFO_DEPTH(16)
  ) u_dut_b (
    .clk_tx            (clk),
    .rst_clk_tx        (rst_b),
    .tx_data           (data_b),
    .write_en          (wr_b),
    .txd_tx            (txd_b),
    .tx_fifo_full      (full_b),
    .tx_fifo_empty     (empty_b),
    .lost_data         (lost_b),
    .tx_busy           (busy_b),
    .tx_frame_indicator(frame_b),
    .tx_bit_indicator  (bit_b)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Bytes expected on the wire, in order, for the frames under observation.
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic       txd;
    logic       busy;
    logic [1:0] st;
    logic       bi;
  } line_t;

  // Expected line for cycle c, given n contiguous frames starting at cycle s
  // with p cycles per bit.
  function automatic line_t model(int c, int s, int p, int n);
    line_t      r;
    logic [7:0] b;
    int         f, off, bn;
    r = '{txd: 1'b1, busy: 1'b0, st: 2'd0, bi: 1'b0};
    if (n > 0 && c >= s && c < s + 10 * p * n) begin
      f   = (c - s) / (10 * p);
      off = (c - s) % (10 * p);
      bn  = off / p;
      b   = exp_q[f];
      r.busy = 1'b1;
      r.bi   = ((off % p) == p - 1);
      if (bn == 0) begin
        r.st  = 2'd1;
        r.txd = 1'b0;
      end else if (bn <= 8) begin
        r.st  = 2'd2;
        r.txd = b[bn-1];
      end else begin
        r.st  = 2'd3;
        r.txd = 1'b1;
      end
    end
    return r;
  endfunction

  // Advance to just after the next rising edge: inputs driven and outputs
  // sampled here belong to cycle 'cyc'.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare the selected instance against the frame model each cycle up to
  // and including 'last'.
  task automatic watch(input bit sel_b, input int s, input int p, input int n,
                       input int last);
    line_t e;
    while (cyc <= last) begin
      e = model(cyc, s, p, n);
      if (sel_b) begin
        check("b_txd",   32'(txd_b),   32'(e.txd));
        check("b_busy",  32'(busy_b),  32'(e.busy));
        check("b_state", 32'(frame_b), 32'(e.st));
        check("b_bit",   32'(bit_b),   32'(e.bi));
      end else begin
        check("a_txd",   32'(txd_a),   32'(e.txd));
        check("a_busy",  32'(busy_a),  32'(e.busy));
        check("a_state", 32'(frame_a), 32'(e.st));
        check("a_bit",   32'(bit_a),   32'(e.bi));
      end
      tick();
    end
  endtask

  // Reset instance A with a write held during reset, then verify reset values
  // and that the write left no trace.
  task automatic reset_a();
    rst_a  = 1'b1;
    wr_a   = 1'b1;
    data_a = 8'hEE;
    tick();
    tick();
    rst_a = 1'b0;
    wr_a  = 1'b0;
    check("rst_txd",   32'(txd_a),   32'd1);
    check("rst_full",  32'(full_a),  32'd0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_lost",  32'(lost_a),  32'd0);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_state", 32'(frame_a), 32'd0);
    check("rst_bit",   32'(bit_a),   32'd0);
    tick();
    check("rst_wr_ignored_empty", 32'(empty_a), 32'd1);
    check("rst_wr_ignored_txd",   32'(txd_a),   32'd1);
  endtask

  initial begin
    rst_a  = 1'b1;
    wr_a   = 1'b0;
    data_a = 8'h00;
    rst_b  = 1'b1;
    wr_b   = 1'b0;
    data_b = 8'h00;
    tick();
    reset_a();

    // Single byte 0x55 written at cycle 0: start bit from cycle 2.
    cyc    = 0;
    data_a = 8'h55;
    wr_a   = 1'b1;
    tick();
    wr_a = 1'b0;
    check("single_empty_c1", 32'(empty_a), 32'd0);
    check("single_busy_c1",  32'(busy_a),  32'd0);
    check("single_txd_c1",   32'(txd_a),   32'd1);
    tick();
    check("single_empty_c2", 32'(empty_a), 32'd1);
    exp_q.delete();
    exp_q.push_back(8'h55);
    watch(1'b0, 2, 16, 1, 170);

    // Back-to-back 0xA5, 0x3C: second start bit at cycle 162.
    cyc    = 0;
    data_a = 8'hA5;
    wr_a   = 1'b1;
    tick();
    data_a = 8'h3C;
    check("b2b_empty_c1", 32'(empty_a), 32'd0);
    tick();
    wr_a = 1'b0;
    check("b2b_empty_c2", 32'(empty_a), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    watch(1'b0, 2, 16, 2, 160);
    check("b2b_empty_c161", 32'(empty_a), 32'd0);
    watch(1'b0, 2, 16, 2, 161);
    check("b2b_empty_c162", 32'(empty_a), 32'd1);
    watch(1'b0, 2, 16, 2, 330);

    // Overflow: 18 writes on cycles 0-17, the last one dropped.
    cyc = 0;
    exp_q.delete();
    for (int i = 0; i < 18; i++) begin
      data_a = 8'(32'h20 + i);
      wr_a   = 1'b1;
      if (i < 17) exp_q.push_back(8'(32'h20 + i));
      if (i == 16) check("ovf_full_c16", 32'(full_a), 32'd0);
      if (i == 17) begin
        check("ovf_full_c17", 32'(full_a), 32'd1);
        check("ovf_lost_c17", 32'(lost_a), 32'd0);
      end
      tick();
    end
    wr_a = 1'b0;
    check("ovf_lost_c18", 32'(lost_a), 32'd1);
    check("ovf_full_c18", 32'(full_a), 32'd1);
    watch(1'b0, 2, 16, 17, 161);
    check("ovf_full_c162", 32'(full_a), 32'd0);
    watch(1'b0, 2, 16, 17, 2 + 17 * 160 + 4);
    check("ovf_lost_end",  32'(lost_a),  32'd1);
    check("ovf_empty_end", 32'(empty_a), 32'd1);

    // Write while full in the same cycle as the STOP->START pop.
    reset_a();
    cyc = 0;
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      data_a = 8'(32'h40 + i);
      wr_a   = 1'b1;
      exp_q.push_back(8'(32'h40 + i));
      tick();
    end
    wr_a = 1'b0;
    check("pp_full_c17", 32'(full_a), 32'd1);
    exp_q.push_back(8'h51);
    watch(1'b0, 2, 16, 18, 160);
    data_a = 8'hEE;
    wr_a   = 1'b1;
    check("pp_full_c161", 32'(full_a), 32'd1);
    check("pp_lost_c161", 32'(lost_a), 32'd0);
    tick();
    data_a = 8'h51;
    check("pp_full_c162", 32'(full_a), 32'd0);
    check("pp_lost_c162", 32'(lost_a), 32'd1);
    tick();
    wr_a = 1'b0;
    check("pp_refill_full_c163", 32'(full_a), 32'd1);
    watch(1'b0, 2, 16, 18, 2 + 18 * 160 + 4);
    check("pp_empty_end", 32'(empty_a), 32'd1);
    check("pp_lost_end",  32'(lost_a),  32'd1);

    // Reset during DATA bit 3 with bytes still queued.
    cyc = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      data_a = 8'(32'h61 + i);
      wr_a   = 1'b1;
      exp_q.push_back(8'(32'h61 + i));
      tick();
    end
    wr_a = 1'b0;
    watch(1'b0, 2, 16, 4, 69);
    rst_a  = 1'b1;
    wr_a   = 1'b1;
    data_a = 8'h77;
    tick();
    rst_a = 1'b0;
    wr_a  = 1'b0;
    check("midrst_txd",   32'(txd_a),   32'd1);
    check("midrst_state", 32'(frame_a), 32'd0);
    check("midrst_busy",  32'(busy_a),  32'd0);
    check("midrst_empty", 32'(empty_a), 32'd1);
    check("midrst_lost",  32'(lost_a),  32'd0);
    check("midrst_full",  32'(full_a),  32'd0);
    exp_q.delete();
    watch(1'b0, 0, 16, 0, 471);
    check("midrst_empty_end", 32'(empty_a), 32'd1);

    // DIVISOR=27: pop on the first baud enable (cycle 26), 432-cycle bits.
    cyc    = 0;
    rst_b  = 1'b0;
    data_b = 8'h55;
    wr_b   = 1'b1;
    check("div_txd_c0",  32'(txd_b),  32'd1);
    check("div_busy_c0", 32'(busy_b), 32'd0);
    tick();
    wr_b = 1'b0;
    check("div_empty_c1", 32'(empty_b), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h55);
    watch(1'b1, 27, 432, 1, 26);
    check("div_empty_c27", 32'(empty_b), 32'd1);
    watch(1'b1, 27, 432, 1, 27 + 4320 + 30);
    check("div_lost_end", 32'(lost_b), 32'd0);
    check("div_full_end", 32'(full_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
